axis_slave_rx: RTL and testbench
================================

Name: axis_slave_rx

Overview:
- AXI4-Stream slave receive stage that sits directly downstream of the stream master.
- Accepts M_AXIS-style beats (TDATA/TVALID/TLAST/TSTRB) with real backpressure via S_AXIS_TREADY.
- Buffers beats in a first-word-fall-through FIFO and presents them on a valid/ready output port to the consuming logic.
- Tracks per-packet statistics: beat count, last packet length, packet count, and a TSTRB error flag.

Parameters:
FIFO_DEPTH, 4, number of buffered beats; power of two, >= 2
C_S_AXIS_TDATA_WIDTH, 32, stream data width; multiple of 8
CNT_WIDTH, 16, width of the beat, length and packet counters

Ports:
S_AXIS_ACLK  in  1  single clock, rising edge
S_AXIS_ARESET  in  1  synchronous active-high reset
S_AXIS_TDATA  in  C_S_AXIS_TDATA_WIDTH  stream data
S_AXIS_TSTRB  in  C_S_AXIS_TDATA_WIDTH/8  byte strobes (checked, not stored)
S_AXIS_TVALID  in  1  beat valid
S_AXIS_TLAST  in  1  last beat of packet
S_AXIS_TREADY  out  1  slave ready
DATA_out  out  C_S_AXIS_TDATA_WIDTH  head-of-FIFO data
LAST_out  out  1  head-of-FIFO TLAST
VALID_out  out  1  FIFO not empty
READY_out  in  1  consumer accepts head beat
BEAT_CNT  out  CNT_WIDTH  beats accepted in the current, unfinished packet
LAST_PKT_LEN  out  CNT_WIDTH  beat count of the most recently completed packet
PKT_CNT  out  CNT_WIDTH  completed packets
STRB_ERR  out  1  sticky: an accepted beat had TSTRB not all ones

Behaviour:
- Handshake events:
  - push = S_AXIS_TVALID && S_AXIS_TREADY.
  - pop = VALID_out && READY_out.
- Storage and state registers:
  - FIFO entries are {TLAST, TDATA}.
  - Registers: wr_ptr and rd_ptr (clogb2(FIFO_DEPTH-1) bits each) and count (0..FIFO_DEPTH).
  - Pointers wrap modulo FIFO_DEPTH.
- S_AXIS_TREADY:
  - Equals (count != FIFO_DEPTH) && !S_AXIS_ARESET.
  - Decoded from registers only; no combinational path from S_AXIS_TVALID or READY_out.
- Output port:
  - VALID_out = (count != 0).
  - DATA_out and LAST_out = fifo[rd_ptr], first-word-fall-through.
- Latency: a beat pushed at edge N appears on DATA_out/VALID_out after edge N when the FIFO was empty. There is no pass-through in the same cycle.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged, both pointers advance.
- Full: S_AXIS_TREADY is 0, so no push occurs. A pop at full raises TREADY in the next cycle, not the same cycle.
- Empty: VALID_out is 0; READY_out is ignored.
- Holding: DATA_out/LAST_out stay stable while VALID_out=1 and READY_out=0.
- Statistics, evaluated on push:
  - TLAST=0: BEAT_CNT <= BEAT_CNT+1, saturating at all ones.
  - TLAST=1: LAST_PKT_LEN <= BEAT_CNT+1 (saturating), BEAT_CNT <= 0, PKT_CNT <= PKT_CNT+1 (wraps).
  - A single-beat packet gives LAST_PKT_LEN=1.
- STRB_ERR: set on any push with S_AXIS_TSTRB != all ones; cleared only by reset.
- Reset, synchronous, checked at the clock edge:
  - Pointers, count and FIFO contents go to 0.
  - BEAT_CNT, LAST_PKT_LEN, PKT_CNT and STRB_ERR go to 0.
  - S_AXIS_TREADY=0 while reset is high. VALID_out=0, DATA_out=0 and LAST_out=0 from the first edge with reset high.
- Reset mid-packet: buffered beats are discarded and BEAT_CNT clears. No partial packet is counted.
- First cycle after reset deasserts: S_AXIS_TREADY=1.

Test Plan:
1. Reset held 3 cycles, then released, with TVALID=1 during reset -> TREADY=0, VALID_out=0 and all counters 0 during reset; no beats stored; TREADY=1 on the first cycle after release.
2. Push 0x11,0x22,0x33(TLAST) with READY_out=1 -> DATA_out sequence 0x11,0x22,0x33; LAST_out=1 only on 0x33; LAST_PKT_LEN=3, PKT_CNT=1, BEAT_CNT=0.
3. READY_out=0 with continuous TVALID for 6 beats (DEPTH=4) -> exactly 4 accepted; TREADY=0 from the cycle after the 4th push. Then raise READY_out for one cycle -> one pop, TREADY=1 the next cycle, 5th beat accepted, order preserved.
4. FIFO holding 2 beats, push and pop in the same cycle -> count stays 2 and both pointers advance; run 10 beats through to check wrap-around with no loss or duplication.
5. One beat with TSTRB=4'b0111, then clean beats -> STRB_ERR=1 and stays 1 until reset; data is still delivered unchanged.
6. Reset asserted after 2 beats of a packet are pushed -> FIFO empty, BEAT_CNT=0, PKT_CNT unchanged at 0; a following 1-beat TLAST packet gives LAST_PKT_LEN=1, PKT_CNT=1.

Source files
------------

// File: rtl/axis_slave_rx.sv
// AXI4-Stream slave receive stage: FWFT buffer between the stream master and a
// valid/ready consumer, with per-packet beat/length/packet statistics and a TSTRB error flag.
module axis_slave_rx #(
   parameter int FIFO_DEPTH           = 4,
   parameter int C_S_AXIS_TDATA_WIDTH = 32,
   parameter int CNT_WIDTH            = 16
) (
   input  logic                              S_AXIS_ACLK,
   input  logic                              S_AXIS_ARESET,
   input  logic [C_S_AXIS_TDATA_WIDTH-1:0]   S_AXIS_TDATA,
   input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0] S_AXIS_TSTRB,
   input  logic                              S_AXIS_TVALID,
   input  logic                              S_AXIS_TLAST,
   output logic                              S_AXIS_TREADY,
   output logic [C_S_AXIS_TDATA_WIDTH-1:0]   DATA_out,
   output logic                              LAST_out,
   output logic                              VALID_out,
   input  logic                              READY_out,
   output logic [CNT_WIDTH-1:0]              BEAT_CNT,
   output logic [CNT_WIDTH-1:0]              LAST_PKT_LEN,
   output logic [CNT_WIDTH-1:0]              PKT_CNT,
   output logic                              STRB_ERR
);

   function automatic int clogb2(input int value);
      int v;
      int res;
      v   = value;
      res = 0;
      while (v > 0) begin
         res = res + 1;
         v   = v >> 1;
      end
      if (res < 1) begin
         res = 1;
      end
      return res;
   endfunction

   localparam int PTR_W   = clogb2(FIFO_DEPTH - 1);
   localparam int FILL_W  = PTR_W + 1;
   localparam int STRB_W  = C_S_AXIS_TDATA_WIDTH / 8;
   localparam int ENTRY_W = C_S_AXIS_TDATA_WIDTH + 1;

   localparam logic [PTR_W-1:0]     PTR_ONE   = PTR_W'(1'b1);
   localparam logic [FILL_W-1:0]    FILL_ONE  = FILL_W'(1'b1);
   localparam logic [FILL_W-1:0]    FILL_FULL = FILL_W'(FIFO_DEPTH);
   localparam logic [FILL_W-1:0]    FILL_ZERO = {FILL_W{1'b0}};
   localparam logic [CNT_WIDTH-1:0] CNT_ZERO  = {CNT_WIDTH{1'b0}};
   localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1'b1);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX   = {CNT_WIDTH{1'b1}};
   localparam logic [STRB_W-1:0]    STRB_ALL  = {STRB_W{1'b1}};

   logic [ENTRY_W-1:0]   mem_r [FIFO_DEPTH];
   logic [PTR_W-1:0]     wr_ptr_r;
   logic [PTR_W-1:0]     rd_ptr_r;
   logic [FILL_W-1:0]    fill_r;
   logic [FILL_W-1:0]    fill_nxt_s;
   logic                 tready_s;
   logic                 valid_s;
   logic                 push_s;
   logic                 pop_s;
   logic [ENTRY_W-1:0]   head_s;
   logic [CNT_WIDTH-1:0] beat_cnt_r;
   logic [CNT_WIDTH-1:0] beat_inc_s;
   logic [CNT_WIDTH-1:0] last_len_r;
   logic [CNT_WIDTH-1:0] pkt_cnt_r;
   logic                 strb_err_r;

   // Handshake decode, saturated beat increment and next fill level.
   always_comb begin
      tready_s   = (fill_r != FILL_FULL) && !S_AXIS_ARESET;
      valid_s    = (fill_r != FILL_ZERO);
      push_s     = S_AXIS_TVALID && tready_s;
      pop_s      = valid_s && READY_out;
      head_s     = mem_r[rd_ptr_r];
      beat_inc_s = beat_cnt_r;
      fill_nxt_s = fill_r;
      if (beat_cnt_r == CNT_MAX) begin
         beat_inc_s = CNT_MAX;
      end else begin
         beat_inc_s = beat_cnt_r + CNT_ONE;
      end
      case ({push_s, pop_s})
         2'b10:   fill_nxt_s = fill_r + FILL_ONE;
         2'b01:   fill_nxt_s = fill_r - FILL_ONE;
         default: fill_nxt_s = fill_r;
      endcase
   end

   // FIFO storage, pointers and fill level; pointers wrap naturally at the power-of-two depth.
   always_ff @(posedge S_AXIS_ACLK) begin
      if (S_AXIS_ARESET) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_r[i] <= {ENTRY_W{1'b0}};
         end
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         fill_r   <= FILL_ZERO;
      end else begin
         if (push_s) begin
            mem_r[wr_ptr_r] <= {S_AXIS_TLAST, S_AXIS_TDATA};
            wr_ptr_r        <= wr_ptr_r + PTR_ONE;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         fill_r <= fill_nxt_s;
      end
   end

   // Packet statistics, updated only on accepted beats; a reset drops any partial packet.
   always_ff @(posedge S_AXIS_ACLK) begin
      if (S_AXIS_ARESET) begin
         beat_cnt_r <= CNT_ZERO;
         last_len_r <= CNT_ZERO;
         pkt_cnt_r  <= CNT_ZERO;
         strb_err_r <= 1'b0;
      end else if (push_s) begin
         if (S_AXIS_TLAST) begin
            last_len_r <= beat_inc_s;
            beat_cnt_r <= CNT_ZERO;
            pkt_cnt_r  <= pkt_cnt_r + CNT_ONE;
         end else begin
            beat_cnt_r <= beat_inc_s;
         end
         if (S_AXIS_TSTRB != STRB_ALL) begin
            strb_err_r <= 1'b1;
         end
      end
   end

   assign S_AXIS_TREADY = tready_s;
   assign VALID_out     = valid_s;
   assign DATA_out      = head_s[C_S_AXIS_TDATA_WIDTH-1:0];
   assign LAST_out      = head_s[C_S_AXIS_TDATA_WIDTH];
   assign BEAT_CNT      = beat_cnt_r;
   assign LAST_PKT_LEN  = last_len_r;
   assign PKT_CNT       = pkt_cnt_r;
   assign STRB_ERR      = strb_err_r;

endmodule

// File: tb/tb_axis_slave_rx.sv
// Bench for axis_slave_rx: directed steps then random traffic, checked against a
// queue-based reference of the stream plus packet statistics.
module tb_axis_slave_rx;

   localparam int DEPTH = 4;

   logic        clk;
   logic        rst;
   logic [31:0] tdata;
   logic [3:0]  tstrb;
   logic        tvalid;
   logic        tlast;
   logic        tready;
   logic [31:0] data_out;
   logic        last_out;
   logic        valid_out;
   logic        ready_out;
   logic [15:0] beat_cnt;
   logic [15:0] last_len;
   logic [15:0] pkt_cnt;
   logic        strb_err;

   int n_assert;
   int n_fail;

   logic [32:0] q[$];
   logic [15:0] m_beat;
   logic [15:0] m_len;
   logic [15:0] m_pkt;
   logic        m_err;

   axis_slave_rx #(
      .FIFO_DEPTH(DEPTH),
      .C_S_AXIS_TDATA_WIDTH(32),
      .CNT_WIDTH(16)
   ) dut (
      .S_AXIS_ACLK  (clk),
      .S_AXIS_ARESET(rst),
      .S_AXIS_TDATA (tdata),
      .S_AXIS_TSTRB (tstrb),
      .S_AXIS_TVALID(tvalid),
      .S_AXIS_TLAST (tlast),
      .S_AXIS_TREADY(tready),
      .DATA_out     (data_out),
      .LAST_out     (last_out),
      .VALID_out    (valid_out),
      .READY_out    (ready_out),
      .BEAT_CNT     (beat_cnt),
      .LAST_PKT_LEN (last_len),
      .PKT_CNT      (pkt_cnt),
      .STRB_ERR     (strb_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: drive inputs, check outputs against the reference, then advance the reference.
   task automatic step(input logic r_i, input logic v_i, input logic [31:0] d_i,
                       input logic l_i, input logic [3:0] s_i, input logic rdy_i);
      logic push;
      logic pop;
      rst = r_i; tvalid = v_i; tdata = d_i; tlast = l_i; tstrb = s_i; ready_out = rdy_i;
      #1;
      chk("tready", tready, (!r_i && (q.size() < DEPTH)));
      chk("valid_out", valid_out, (q.size() != 0));
      if (q.size() != 0) begin
         chk("data_out", data_out, q[0][31:0]);
         chk("last_out", last_out, q[0][32]);
      end
      chk("beat_cnt", beat_cnt, m_beat);
      chk("last_pkt_len", last_len, m_len);
      chk("pkt_cnt", pkt_cnt, m_pkt);
      chk("strb_err", strb_err, m_err);
      push = v_i && !r_i && (q.size() < DEPTH);
      pop  = rdy_i && !r_i && (q.size() != 0);
      @(posedge clk);
      if (r_i) begin
         q.delete();
         m_beat = 16'd0; m_len = 16'd0; m_pkt = 16'd0; m_err = 1'b0;
      end else begin
         if (pop) void'(q.pop_front());
         if (push) begin
            q.push_back({l_i, d_i});
            if (l_i) begin
               m_len  = (m_beat == 16'hFFFF) ? 16'hFFFF : m_beat + 16'd1;
               m_beat = 16'd0;
               m_pkt  = m_pkt + 16'd1;
            end else begin
               m_beat = (m_beat == 16'hFFFF) ? 16'hFFFF : m_beat + 16'd1;
            end
            if (s_i != 4'hF) m_err = 1'b1;
         end
      end
      #1;
   endtask

   initial begin
      n_assert = 0; n_fail = 0;
      m_beat = 16'd0; m_len = 16'd0; m_pkt = 16'd0; m_err = 1'b0;
      rst = 1'b1; tvalid = 1'b0; tdata = 32'd0; tlast = 1'b0; tstrb = 4'hF; ready_out = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Reset held with TVALID high: nothing stored, TREADY low.
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 32'hAA + i, 1'b0, 4'hF, 1'b1);
      chk("rst_data_out", data_out, 32'd0);
      chk("rst_last_out", last_out, 1'b0);
      step(1'b0, 1'b0, 32'd0, 1'b0, 4'hF, 1'b0);
      chk("rel_tready", tready, 1'b1);
      chk("rel_valid", valid_out, 1'b0);

      // Three-beat packet straight through.
      step(1'b0, 1'b1, 32'h11, 1'b0, 4'hF, 1'b1);
      step(1'b0, 1'b1, 32'h22, 1'b0, 4'hF, 1'b1);
      step(1'b0, 1'b1, 32'h33, 1'b1, 4'hF, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'd0, 1'b0, 4'hF, 1'b1);
      chk("t2_len", last_len, 16'd3);
      chk("t2_pkt", pkt_cnt, 16'd1);
      chk("t2_beat", beat_cnt, 16'd0);

      // Fill to full under backpressure, single pop, then one more accepted.
      for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 32'h100 + i, 1'b0, 4'hF, 1'b0);
      chk("t3_full_tready", tready, 1'b0);
      step(1'b0, 1'b1, 32'h200, 1'b0, 4'hF, 1'b1);
      step(1'b0, 1'b1, 32'h200, 1'b0, 4'hF, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'd0, 1'b0, 4'hF, 1'b1);
      chk("t3_beat", beat_cnt, 16'd5);

      // Simultaneous push/pop at level 2 across pointer wrap.
      step(1'b0, 1'b1, 32'h300, 1'b0, 4'hF, 1'b0);
      step(1'b0, 1'b1, 32'h301, 1'b0, 4'hF, 1'b0);
      for (int i = 0; i < 10; i++)
         step(1'b0, 1'b1, 32'h310 + i, (i == 9), 4'hF, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'd0, 1'b0, 4'hF, 1'b1);
      chk("t4_len", last_len, 16'd17);
      chk("t4_pkt", pkt_cnt, 16'd2);

      // Partial strobe sets the sticky error; data still delivered.
      step(1'b0, 1'b1, 32'hA5, 1'b0, 4'b0111, 1'b1);
      step(1'b0, 1'b1, 32'hB1, 1'b0, 4'hF, 1'b1);
      step(1'b0, 1'b1, 32'hB2, 1'b0, 4'hF, 1'b1);
      step(1'b0, 1'b1, 32'hB3, 1'b1, 4'hF, 1'b1);
      for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 32'd0, 1'b0, 4'hF, 1'b1);
      chk("t5_err", strb_err, 1'b1);
      chk("t5_len", last_len, 16'd4);

      // Reset mid-packet discards buffered beats and the partial count.
      step(1'b0, 1'b1, 32'h600, 1'b0, 4'hF, 1'b0);
      step(1'b0, 1'b1, 32'h601, 1'b0, 4'hF, 1'b0);
      step(1'b1, 1'b0, 32'd0, 1'b0, 4'hF, 1'b0);
      chk("t6_valid", valid_out, 1'b0);
      chk("t6_beat", beat_cnt, 16'd0);
      chk("t6_pkt", pkt_cnt, 16'd0);
      chk("t6_err", strb_err, 1'b0);
      step(1'b0, 1'b1, 32'h700, 1'b1, 4'hF, 1'b1);
      step(1'b0, 1'b0, 32'd0, 1'b0, 4'hF, 1'b1);
      chk("t6_len", last_len, 16'd1);
      chk("t6_pkt1", pkt_cnt, 16'd1);

      // Random traffic against the reference.
      for (int i = 0; i < 400; i++) begin
         logic [3:0] s;
         s = (($urandom % 16) == 0) ? 4'($urandom) : 4'hF;
         step(1'b0, 1'($urandom), $urandom, (($urandom % 4) == 0), s, 1'($urandom));
      end
      for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 1'b0, 32'd0, 1'b0, 4'hF, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
